// File: rtl/sda_tx_sched_pkg.sv
// Shared types and constants for the SDA transmit scheduler:
// FSM state encoding, default widths and a width helper.
package sda_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } sched_state_e;

   localparam int DW_DEF      = 4;
   localparam int TIMEOUT_DEF = 64;

   // Never returns 0 so that a 1-bit index still exists for tiny configs.
   function automatic int sda_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/sda_tx_sched_if.sv
// Requester and serializer signal bundle of the scheduler.
// master = producers/serializer side, slave = the scheduler.
interface sda_tx_sched_if #(
   parameter int NREQ = 4,
   parameter int DW   = 4
) ();

   // A nibble moves on a rising clock edge where req_valid[i] & req_ready[i];
   // valid may be raised freely, ready depends only on slot occupancy.
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               tx_start;
   logic [DW-1:0]      tx_data;
   logic               tx_busy;
   logic               tx_done;

   modport master (
      output req_valid, req_data, tx_busy, tx_done,
      input  req_ready, tx_start, tx_data
   );

   modport slave (
      input  req_valid, req_data, tx_busy, tx_done,
      output req_ready, tx_start, tx_data
   );

endinterface

// File: rtl/sda_tx_sched_rr_pick.sv
// Combinational round-robin selector: first pending slot after last_grant.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int GW   = 2
) (
   input  logic [NREQ-1:0] pending,
   input  logic [GW-1:0]   last_grant,
   output logic            any,
   output logic [GW-1:0]   winner
);

   localparam logic [GW-1:0] LAST_IDX = GW'(NREQ - 1);

   logic [GW-1:0] w_idx;

   always_comb begin
      any    = 1'b0;
      winner = '0;
      w_idx  = last_grant;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
         if (!any && pending[w_idx]) begin
            any    = 1'b1;
            winner = w_idx;
         end
      end
   end

endmodule

// File: rtl/sda_tx_sched.sv
// Round-robin scheduler sharing one SDA/SCL frame serializer between NREQ
// single-nibble slots, with a per-frame watchdog.
module sda_tx_sched
   import sda_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                       sclk,
   input  logic                       rst,
   sda_tx_sched_if.slave              bus,
   output logic [sda_clog2(NREQ)-1:0] grant_id,
   output logic                       grant_valid,
   output logic                       done_pulse,
   output logic                       err_timeout,
   output sched_state_e               o_dbg_state
);

   localparam int GW = sda_clog2(NREQ);
   localparam int WW = sda_clog2(TIMEOUT) + 1;
   localparam logic [WW-1:0]   WD_LAST = WW'(TIMEOUT - 1);
   localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_ISSUE = ST_ISSUE;
   localparam logic [1:0] S_WAIT  = ST_WAIT;

   logic [1:0]      r_state;
   logic [NREQ-1:0] r_pending;
   logic [GW-1:0]   r_last;
   logic [GW-1:0]   r_grant;
   logic [DW-1:0]   r_data;
   logic [WW-1:0]   r_wd;
   logic            r_done;
   logic            r_err;

   logic            w_any;
   logic [GW-1:0]   w_winner;
   logic [DW-1:0]   w_win_data;
   logic [NREQ-1:0] w_accept;
   logic [NREQ-1:0] w_clear;
   logic            w_fin_done;
   logic            w_fin_to;

   rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
      .pending    (r_pending),
      .last_grant (r_last),
      .any        (w_any),
      .winner     (w_winner)
   );

   always_comb begin
      w_win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_winner == GW'(i)) w_win_data = bus.req_data[i*DW +: DW];
      end
   end

   // tx_done beats the watchdog when both land on the same WAIT cycle.
   assign w_accept   = bus.req_valid & ~r_pending;
   assign w_fin_done = (r_state == S_WAIT) && bus.tx_done;
   assign w_fin_to   = (r_state == S_WAIT) && !bus.tx_done && ((r_wd + 1'b1) == WD_LAST);
   assign w_clear    = (w_fin_done || w_fin_to) ? (ONE_HOT << r_grant) : '0;

   always_ff @(posedge sclk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_pending <= '0;
         r_last    <= GW'(NREQ - 1);
         r_grant   <= '0;
         r_data    <= '0;
         r_wd      <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_pending <= (r_pending | w_accept) & ~w_clear;
         r_done    <= w_fin_done;
         r_err     <= w_fin_to;
         case (r_state)
            S_IDLE: begin
               if (w_any && !bus.tx_busy) begin
                  r_grant <= w_winner;
                  r_data  <= w_win_data;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_wd    <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_wd <= r_wd + 1'b1;
               if (w_fin_done || w_fin_to) begin
                  r_last  <= r_grant;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = ~r_pending;
   assign bus.tx_start  = (r_state == S_ISSUE);
   assign bus.tx_data   = r_data;
   assign grant_id      = r_grant;
   assign grant_valid   = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign done_pulse    = r_done;
   assign err_timeout   = r_err;
   assign o_dbg_state   = sched_state_e'(r_state);

endmodule

// File: tb/tb_sda_tx_sched.sv
// Directed bench for sda_tx_sched: dut_a uses the default watchdog,
// dut_b a short TIMEOUT=8 watchdog for the expiry scenarios.
module tb_sda_tx_sched;
   import sda_pkg::*;

   logic sclk = 1'b0;
   logic rst  = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 sclk = ~sclk;

   sda_tx_sched_if #(.NREQ(4), .DW(4)) ifa ();
   sda_tx_sched_if #(.NREQ(4), .DW(4)) ifb ();

   logic [1:0]   gid_a, gid_b;
   logic         gv_a, gv_b, dp_a, dp_b, et_a, et_b;
   sched_state_e st_a, st_b;

   sda_tx_sched #(.NREQ(4), .DW(4), .TIMEOUT(64)) dut_a (
      .sclk(sclk), .rst(rst), .bus(ifa.slave),
      .grant_id(gid_a), .grant_valid(gv_a), .done_pulse(dp_a),
      .err_timeout(et_a), .o_dbg_state(st_a)
   );

   sda_tx_sched #(.NREQ(4), .DW(4), .TIMEOUT(8)) dut_b (
      .sclk(sclk), .rst(rst), .bus(ifb.slave),
      .grant_id(gid_b), .grant_valid(gv_b), .done_pulse(dp_b),
      .err_timeout(et_b), .o_dbg_state(st_b)
   );

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      int starts;
      starts = 0;
      do_reset();
      rst = 1'b0;
      step();
      n_checks++;
      if (ifa.req_ready !== 4'hF || ifa.tx_start !== 1'b0 || ifa.tx_data !== 4'h0 || gid_a !== 2'd0 ||
          gv_a !== 1'b0 || dp_a !== 1'b0 || et_a !== 1'b0 || ifb.req_ready !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_values: ready=%h start=%b data=%h gid=%0d gv=%b dp=%b et=%b readyb=%h, want ready=f and rest 0",
                  ifa.req_ready, ifa.tx_start, ifa.tx_data, gid_a, gv_a, dp_a, et_a, ifb.req_ready);
      end
      rst = 1'b1;
      step();
      ifa.req_valid = 4'b0010;
      ifa.req_data  = 16'h0050;
      step();
      ifa.req_valid = 4'b0000;
      step();
      n_checks++;
      if (ifa.tx_start !== 1'b1 || gid_a !== 2'd1) begin
         n_fail++;
         $display("FAIL reset_pre_issue: start=%b gid=%0d, want 1 and 1", ifa.tx_start, gid_a);
      end
      step();
      n_checks++;
      if (gv_a !== 1'b1 || st_a !== ST_WAIT) begin
         n_fail++;
         $display("FAIL reset_pre_wait: gv=%b state=%0d, want 1 and WAIT", gv_a, st_a);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (ifa.req_ready !== 4'hF || ifa.tx_start !== 1'b0 || ifa.tx_data !== 4'h0 || gid_a !== 2'd0 ||
          gv_a !== 1'b0 || dp_a !== 1'b0 || et_a !== 1'b0 || st_a !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_mid_frame: ready=%h start=%b data=%h gid=%0d gv=%b dp=%b et=%b, want ready=f and rest 0",
                  ifa.req_ready, ifa.tx_start, ifa.tx_data, gid_a, gv_a, dp_a, et_a);
      end
      rst = 1'b1;
      repeat (15) begin
         step();
         if (ifa.tx_start === 1'b1 || dp_a === 1'b1 || et_a === 1'b1) starts++;
      end
      n_checks++;
      if (starts != 0 || ifa.req_ready !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_no_restart: pulses=%0d ready=%h, want 0 and f", starts, ifa.req_ready);
      end
   endtask

   task automatic test_single();
      ifa.req_valid = 4'b0100;
      ifa.req_data  = 16'h0A00;
      step();
      ifa.req_valid = 4'b0000;
      n_checks++;
      if (ifa.tx_start !== 1'b0 || ifa.req_ready !== 4'b1011) begin
         n_fail++;
         $display("FAIL single_t1: start=%b ready=%h, want 0 and b", ifa.tx_start, ifa.req_ready);
      end
      step();
      n_checks++;
      if (ifa.tx_start !== 1'b1 || ifa.tx_data !== 4'hA || gid_a !== 2'd2 || gv_a !== 1'b1) begin
         n_fail++;
         $display("FAIL single_issue: start=%b data=%h gid=%0d gv=%b, want 1 a 2 1", ifa.tx_start, ifa.tx_data, gid_a, gv_a);
      end
      repeat (8) step();
      n_checks++;
      if (ifa.tx_start !== 1'b0 || ifa.tx_data !== 4'hA || ifa.req_ready[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_wait: start=%b data=%h ready2=%b, want 0 a 0", ifa.tx_start, ifa.tx_data, ifa.req_ready[2]);
      end
      ifa.tx_done = 1'b1;
      step();
      ifa.tx_done = 1'b0;
      n_checks++;
      if (dp_a !== 1'b1 || et_a !== 1'b0 || ifa.req_ready[2] !== 1'b1 || gv_a !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: dp=%b et=%b ready2=%b gv=%b, want 1 0 1 0", dp_a, et_a, ifa.req_ready[2], gv_a);
      end
      step();
      n_checks++;
      if (dp_a !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done_width: dp=%b, want 0", dp_a);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_id [6];
      logic [3:0] exp_d  [6];
      int n;
      exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
      exp_d  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9};
      do_reset();
      ifa.req_valid = 4'hF;
      ifa.req_data  = 16'h4321;
      step();
      ifa.req_valid = 4'h0;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) begin
            ifa.req_valid = 4'b1001;
            ifa.req_data  = 16'h9008;
            step();
            ifa.req_valid = 4'h0;
         end
         n = 0;
         while (ifa.tx_start !== 1'b1 && n < 20) begin
            step();
            n++;
         end
         n_checks++;
         if (n != 1 || gid_a !== exp_id[k] || ifa.tx_data !== exp_d[k]) begin
            n_fail++;
            $display("FAIL rr_frame%0d: wait=%0d gid=%0d data=%h, want 1 %0d %h", k, n, gid_a, ifa.tx_data, exp_id[k], exp_d[k]);
         end
         repeat (5) step();
         ifa.tx_done = 1'b1;
         step();
         ifa.tx_done = 1'b0;
         n_checks++;
         if (dp_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_done%0d: dp=%b, want 1", k, dp_a);
         end
      end
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      do_reset();
      ifb.req_valid = 4'b0110;
      ifb.req_data  = 16'h0760;
      step();
      ifb.req_valid = 4'h0;
      step();
      n_checks++;
      if (ifb.tx_start !== 1'b1 || gid_b !== 2'd1 || ifb.tx_data !== 4'h6) begin
         n_fail++;
         $display("FAIL to_issue: start=%b gid=%0d data=%h, want 1 1 6", ifb.tx_start, gid_b, ifb.tx_data);
      end
      repeat (7) begin
         step();
         if (et_b === 1'b1) early++;
      end
      n_checks++;
      if (early != 0) begin
         n_fail++;
         $display("FAIL to_early: err pulses before expiry=%0d, want 0", early);
      end
      step();
      n_checks++;
      if (et_b !== 1'b1 || dp_b !== 1'b0 || ifb.req_ready !== 4'b1011 || gv_b !== 1'b0) begin
         n_fail++;
         $display("FAIL to_expire: et=%b dp=%b ready=%h gv=%b, want 1 0 b 0", et_b, dp_b, ifb.req_ready, gv_b);
      end
      step();
      n_checks++;
      if (ifb.tx_start !== 1'b1 || gid_b !== 2'd2 || ifb.tx_data !== 4'h7 || et_b !== 1'b0) begin
         n_fail++;
         $display("FAIL to_next_issue: start=%b gid=%0d data=%h et=%b, want 1 2 7 0", ifb.tx_start, gid_b, ifb.tx_data, et_b);
      end
      repeat (2) step();
      ifb.tx_done = 1'b1;
      step();
      ifb.tx_done = 1'b0;
      n_checks++;
      if (dp_b !== 1'b1 || ifb.req_ready !== 4'hF) begin
         n_fail++;
         $display("FAIL to_cleanup: dp=%b ready=%h, want 1 f", dp_b, ifb.req_ready);
      end
   endtask

   task automatic test_done_tie();
      int stray;
      stray = 0;
      ifb.req_valid = 4'b0001;
      ifb.req_data  = 16'h000C;
      step();
      ifb.req_valid = 4'h0;
      step();
      n_checks++;
      if (ifb.tx_start !== 1'b1 || gid_b !== 2'd0) begin
         n_fail++;
         $display("FAIL tie_issue: start=%b gid=%0d, want 1 0", ifb.tx_start, gid_b);
      end
      repeat (7) step();
      ifb.tx_done = 1'b1;
      step();
      ifb.tx_done = 1'b0;
      n_checks++;
      if (dp_b !== 1'b1 || et_b !== 1'b0) begin
         n_fail++;
         $display("FAIL tie_done: dp=%b et=%b, want 1 0", dp_b, et_b);
      end
      step();
      ifb.tx_done = 1'b1;
      step();
      ifb.tx_done = 1'b0;
      if (dp_b === 1'b1 || et_b === 1'b1 || ifb.tx_start === 1'b1) stray++;
      step();
      if (dp_b === 1'b1 || et_b === 1'b1 || ifb.tx_start === 1'b1) stray++;
      n_checks++;
      if (stray != 0) begin
         n_fail++;
         $display("FAIL stray_done: pulses=%0d, want 0", stray);
      end
   endtask

   task automatic test_busy();
      int early;
      int n;
      early = 0;
      ifa.tx_busy   = 1'b1;
      ifa.req_valid = 4'b0010;
      ifa.req_data  = 16'h0030;
      step();
      ifa.req_valid = 4'h0;
      repeat (19) begin
         step();
         if (ifa.tx_start === 1'b1) early++;
      end
      ifa.tx_busy = 1'b0;
      n_checks++;
      if (early != 0 || ifa.tx_start !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_hold: starts while busy=%0d start=%b, want 0 0", early, ifa.tx_start);
      end
      step();
      n_checks++;
      if (ifa.tx_start !== 1'b1 || gid_a !== 2'd1 || ifa.tx_data !== 4'h3) begin
         n_fail++;
         $display("FAIL busy_release: start=%b gid=%0d data=%h, want 1 1 3", ifa.tx_start, gid_a, ifa.tx_data);
      end
      step();
      ifa.req_valid = 4'b1000;
      ifa.req_data  = 16'hE000;
      step();
      ifa.req_valid = 4'h0;
      n_checks++;
      if (ifa.req_ready !== 4'b0101 || gv_a !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_wait_accept: ready=%h gv=%b, want 5 1", ifa.req_ready, gv_a);
      end
      repeat (2) step();
      ifa.tx_done = 1'b1;
      step();
      ifa.tx_done = 1'b0;
      n = 0;
      while (ifa.tx_start !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      n_checks++;
      if (n != 1 || gid_a !== 2'd3 || ifa.tx_data !== 4'hE) begin
         n_fail++;
         $display("FAIL busy_next: wait=%0d gid=%0d data=%h, want 1 3 e", n, gid_a, ifa.tx_data);
      end
      repeat (2) step();
      ifa.tx_done = 1'b1;
      step();
      ifa.tx_done = 1'b0;
      n_checks++;
      if (dp_a !== 1'b1 || ifa.req_ready !== 4'hF) begin
         n_fail++;
         $display("FAIL busy_final: dp=%b ready=%h, want 1 f", dp_a, ifa.req_ready);
      end
   endtask

   initial begin
      ifa.req_valid = '0;
      ifa.req_data  = '0;
      ifa.tx_busy   = 1'b0;
      ifa.tx_done   = 1'b0;
      ifb.req_valid = '0;
      ifb.req_data  = '0;
      ifb.tx_busy   = 1'b0;
      ifb.tx_done   = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_done_tie();
      test_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
